// File: rtl/log_comp_pkg.sv
// Shared constants, state encoding and the pixel-map helper for the log-compression scheduler.
// The optional statistics outputs are enabled with the LOG_COMP_STATS_EN macro.
package log_comp_pkg;

  localparam int INT_W  = 6;
  localparam int FRAC_W = 17;
  localparam int PIX_W  = 8;
  localparam int LOG_W  = INT_W + FRAC_W;

  localparam logic [PIX_W-1:0] PIX_MAX     = {PIX_W{1'b1}};
  localparam logic [LOG_W-1:0] PIX_MAX_EXT = {{(LOG_W-PIX_W){1'b0}}, PIX_MAX};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Floor-subtracted, range-shifted log value before clamping to the pixel range.
  function automatic logic [LOG_W-1:0] log_shift(input logic [LOG_W-1:0] v,
                                                 input logic [LOG_W-1:0] floor_v,
                                                 input logic [4:0]       shift);
    logic [LOG_W-1:0] d;
    d = (v < floor_v) ? '0 : (v - floor_v);
    return d >> shift;
  endfunction

endpackage

// File: rtl/log_comp_result_fifo.sv
// Small synchronous FIFO holding mapped pixels plus their position flags until the
// scan converter accepts them. Push and pop may coincide, including when full.
module log_comp_result_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_pop_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/log_comp_scheduler.sv
// Sequences one frame of envelope samples through the shared log unit and maps results to pixels.
// Define LOG_COMP_STATS_EN to add the sat_count / floor_count statistics outputs.
module log_comp_scheduler
  import log_comp_pkg::*;
#(
  parameter int ENV_W            = 24,
  parameter int SAMPLES_PER_LINE = 512,
  parameter int LINES_PER_FRAME  = 128,
  parameter int MAX_OUT          = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LOG_W-1:0]  floor_q,
  input  logic [4:0]        dr_shift,
  output logic              busy,
  output logic              done,
  input  logic              env_valid,
  input  logic [ENV_W-1:0]  env_data,
  output logic              env_ready,
  output logic              log_in_valid,
  output logic [ENV_W-1:0]  log_in_data,
  input  logic              log_in_ready,
  input  logic              log_out_valid,
  input  logic [INT_W-1:0]  log_out_int,
  input  logic [FRAC_W-1:0] log_out_frac,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_last_sample,
  output logic              pix_last_line,
  input  logic              pix_ready,
  output logic [1:0]        dbg_state
`ifdef LOG_COMP_STATS_EN
  ,
  output logic [15:0]       sat_count,
  output logic [15:0]       floor_count
`endif
);

  localparam int TOTAL = SAMPLES_PER_LINE * LINES_PER_FRAME;
  localparam int IW    = $clog2(TOTAL);
  localparam int SW    = $clog2(SAMPLES_PER_LINE);
  localparam int LW    = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam int CW    = $clog2(MAX_OUT + 1);
`ifdef LOG_COMP_STATS_EN
  localparam int FW    = PIX_W + 4;
`else
  localparam int FW    = PIX_W + 2;
`endif

  // Handshakes: a transfer happens in a cycle where valid && ready; valid never waits on ready.
  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [LOG_W-1:0] r_floor;
  logic [4:0]       r_shift;
  logic [CW-1:0]    r_credits;
  logic [IW-1:0]    r_issue_cnt;
  logic             r_map_valid;
  logic [PIX_W-1:0] r_map_pix;
  logic [SW-1:0]    r_tag_sample;
  logic [LW-1:0]    r_tag_line;

  logic             w_start_ok;
  logic             w_issue_ok;
  logic             w_issue;
  logic             w_last_issue;
  logic             w_pop;
  logic [LOG_W-1:0] w_log_v;
  logic [LOG_W-1:0] w_shifted;
  logic             w_sat;
  logic [PIX_W-1:0] w_pix;
  logic             w_tag_last_s;
  logic             w_tag_last_l;
  logic [FW-1:0]    w_push_data;
  logic [FW-1:0]    w_pop_data;
  logic             w_full;
  logic             w_empty;

  assign w_start_ok   = (r_state == ST_IDLE) && start;
  assign w_issue_ok   = (r_state == ST_RUN) && (r_credits < CW'(MAX_OUT));
  assign log_in_valid = env_valid && w_issue_ok;
  assign env_ready    = log_in_ready && w_issue_ok;
  assign log_in_data  = env_data;
  assign w_issue      = env_valid && env_ready;
  assign w_last_issue = w_issue && (r_issue_cnt == IW'(TOTAL - 1));
  assign w_pop        = pix_valid && pix_ready;

  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_floor <= '0;
      r_shift <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_floor <= floor_q;
            r_shift <= dr_shift;
          end
        end
        ST_RUN: begin
          if (w_last_issue) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_pop && pix_last_sample && pix_last_line) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Credits count samples between issue and pixel acceptance, so the buffer can never overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credits   <= '0;
      r_issue_cnt <= '0;
    end else if (w_start_ok) begin
      r_credits   <= '0;
      r_issue_cnt <= '0;
    end else begin
      if (w_issue) r_issue_cnt <= r_issue_cnt + IW'(1);
      unique case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits + CW'(1);
        2'b01:   r_credits <= r_credits - CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign w_log_v   = {log_out_int, log_out_frac};
  assign w_shifted = log_shift(w_log_v, r_floor, r_shift);
  assign w_sat     = (w_shifted > PIX_MAX_EXT);
  assign w_pix     = w_sat ? PIX_MAX : w_shifted[PIX_W-1:0];

`ifdef LOG_COMP_STATS_EN
  logic r_map_sat;
  logic r_map_below;
  logic w_out_sat;
  logic w_out_below;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_map_valid <= 1'b0;
      r_map_pix   <= '0;
`ifdef LOG_COMP_STATS_EN
      r_map_sat   <= 1'b0;
      r_map_below <= 1'b0;
`endif
    end else begin
      r_map_valid <= log_out_valid && (r_state != ST_IDLE);
      r_map_pix   <= w_pix;
`ifdef LOG_COMP_STATS_EN
      r_map_sat   <= w_sat;
      r_map_below <= (w_log_v < r_floor);
`endif
    end
  end

  // Results return in issue order, so tagging at buffer write gives the same
  // position the pixel has when it is handed downstream.
  assign w_tag_last_s = (r_tag_sample == SW'(SAMPLES_PER_LINE - 1));
  assign w_tag_last_l = (r_tag_line == LW'(LINES_PER_FRAME - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_sample <= '0;
      r_tag_line   <= '0;
    end else if (w_start_ok) begin
      r_tag_sample <= '0;
      r_tag_line   <= '0;
    end else if (r_map_valid) begin
      if (w_tag_last_s) begin
        r_tag_sample <= '0;
        r_tag_line   <= w_tag_last_l ? '0 : r_tag_line + LW'(1);
      end else begin
        r_tag_sample <= r_tag_sample + SW'(1);
      end
    end
  end

`ifdef LOG_COMP_STATS_EN
  assign w_push_data = {r_map_pix, r_map_sat, r_map_below, w_tag_last_s, w_tag_last_l};
  assign {pix_data, w_out_sat, w_out_below, pix_last_sample, pix_last_line} = w_pop_data;
`else
  assign w_push_data = {r_map_pix, w_tag_last_s, w_tag_last_l};
  assign {pix_data, pix_last_sample, pix_last_line} = w_pop_data;
`endif
  assign pix_valid = !w_empty;

  log_comp_result_fifo #(
    .DW    (FW),
    .DEPTH (MAX_OUT)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_map_valid),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_pop_data),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(r_map_valid && w_full && !w_pop));

`ifdef LOG_COMP_STATS_EN
  logic [15:0] r_sat_count;
  logic [15:0] r_floor_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sat_count   <= '0;
      r_floor_count <= '0;
    end else if (w_start_ok) begin
      r_sat_count   <= '0;
      r_floor_count <= '0;
    end else if (w_pop) begin
      if (w_out_sat && (r_sat_count != 16'hFFFF))     r_sat_count   <= r_sat_count + 16'd1;
      if (w_out_below && (r_floor_count != 16'hFFFF)) r_floor_count <= r_floor_count + 16'd1;
    end
  end

  assign sat_count   = r_sat_count;
  assign floor_count = r_floor_count;
`endif

endmodule

// File: tb/tb_log_comp_scheduler.sv
// Bench for log_comp_scheduler: table-driven mapping frames, backpressure, reset and random frames
// against a queue-based reference model; a delay-line model stands in for the log unit.
module tb_log_comp_scheduler;

  localparam int SPL     = 16;
  localparam int LPF     = 4;
  localparam int TOTAL   = SPL * LPF;
  localparam int MAX_OUT = 4;
  localparam int LAT     = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [22:0] floor_q = '0;
  logic [4:0]  dr_shift = '0;
  logic        busy, done, env_ready, log_in_valid;
  logic        env_valid = 1'b0;
  logic [23:0] env_data = '0;
  logic [23:0] log_in_data;
  logic        log_in_ready = 1'b1;
  logic        log_out_valid = 1'b0;
  logic [5:0]  log_out_int = '0;
  logic [16:0] log_out_frac = '0;
  logic        pix_valid, pix_last_sample, pix_last_line;
  logic [7:0]  pix_data;
  logic        pix_ready = 1'b1;
  logic [1:0]  dbg_state;
`ifdef LOG_COMP_STATS_EN
  logic [15:0] sat_count, floor_count;
`endif

  always #5 clk = ~clk;

  log_comp_scheduler #(
    .ENV_W(24), .SAMPLES_PER_LINE(SPL), .LINES_PER_FRAME(LPF), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .floor_q(floor_q), .dr_shift(dr_shift),
    .busy(busy), .done(done), .env_valid(env_valid), .env_data(env_data),
    .env_ready(env_ready), .log_in_valid(log_in_valid), .log_in_data(log_in_data),
    .log_in_ready(log_in_ready), .log_out_valid(log_out_valid), .log_out_int(log_out_int),
    .log_out_frac(log_out_frac), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_last_sample(pix_last_sample), .pix_last_line(pix_last_line),
    .pix_ready(pix_ready), .dbg_state(dbg_state)
`ifdef LOG_COMP_STATS_EN
    , .sat_count(sat_count), .floor_count(floor_count)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_pix(input longint v, input longint f, input int sh);
    longint d;
    longint p;
    d = (v < f) ? 0 : v - f;
    p = d >> sh;
    return (p > 255) ? 255 : int'(p);
  endfunction

  // Reference model state
  logic [22:0] m_floor = '0;
  logic [4:0]  m_shift = '0;
  int          n_iss = 0, n_pix = 0, n_ll = 0, n_done = 0, first_pix = -1;
  bit          exp_done = 0;
  logic [9:0]  exp_q[$];

  // Stimulus modes
  int          env_mode = 0, lr_mode = 0, pr_mode = 0;
  bit          env_const_en = 0;
  logic [23:0] env_const = '0;

  // Log unit stand-in: fixed-latency delay line, result = low 23 bits of the sample
  logic        lm_in_v = 1'b0;
  logic [23:0] lm_in_d = '0;
  logic [23:0] lp [LAT];

  initial begin
    for (int i = 0; i < LAT; i++) lp[i] = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = LAT - 1; i > 0; i--) lp[i] = lp[i-1];
      lp[0] = {lm_in_v, lm_in_d[22:0]};
      log_out_valid = lp[LAT-1][23];
      log_out_int   = lp[LAT-1][22:17];
      log_out_frac  = lp[LAT-1][16:0];
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (env_mode)
        0:       env_valid = 1'b0;
        1:       env_valid = 1'($urandom_range(0, 1));
        default: env_valid = 1'b1;
      endcase
      env_data = env_const_en ? env_const : 24'($urandom);
      case (lr_mode)
        0:       log_in_ready = 1'b1;
        1:       log_in_ready = !log_in_ready;
        default: log_in_ready = 1'($urandom_range(0, 1));
      endcase
      case (pr_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = 1'b0;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard, sampled on the falling edge
  int         mon_rp;
  logic [7:0] mon_rp8;
  logic [9:0] mon_e;

  always @(negedge clk) begin
    lm_in_v = log_in_valid && log_in_ready;
    lm_in_d = log_in_data;
    if (!reset) begin
      if (exp_done || done) check("done_pulse", done, exp_done);
      if (done) n_done++;
      exp_done = 0;
      if (env_valid && env_ready) begin
        mon_rp  = ref_pix(longint'(env_data[22:0]), longint'(m_floor), int'(m_shift));
        mon_rp8 = mon_rp[7:0];
        exp_q.push_back({mon_rp8, (n_iss % SPL) == SPL - 1, (n_iss / SPL) == LPF - 1});
        n_iss++;
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("pix_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pix_data", pix_data, mon_e[9:2]);
          check("pix_last_sample", pix_last_sample, mon_e[1]);
          check("pix_last_line", pix_last_line, mon_e[0]);
        end
        if (n_pix == 0) first_pix = int'(pix_data);
        if (pix_last_line) n_ll++;
        n_pix++;
        if (n_pix == TOTAL) exp_done = 1;
      end
    end
  end

  task automatic do_start(input logic [22:0] f, input logic [4:0] s);
    @(posedge clk); #1;
    floor_q = f; dr_shift = s; start = 1'b1;
    m_floor = f; m_shift = s;
    n_iss = 0; n_pix = 0; n_ll = 0; n_done = 0; first_pix = -1; exp_done = 0;
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
    floor_q = 23'($urandom);
    dr_shift = 5'($urandom);
  endtask

  task automatic poke_start();
    @(posedge clk); #1;
    start = 1'b1; floor_q = 23'($urandom); dr_shift = 5'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_issues(input int n);
    int k = 0;
    while (n_iss < n && k < 2000) begin @(negedge clk); k++; end
    check("issue_wait", n_iss >= n, 1);
  endtask

  task automatic wait_frame();
    int k = 0;
    while (n_done == 0 && k < 3000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    check("frame_done_count", n_done, 1);
    check("frame_busy_after", busy, 0);
    check("frame_issues", n_iss, TOTAL);
    check("frame_pixels", n_pix, TOTAL);
    check("frame_last_line_px", n_ll, SPL);
    check("frame_queue_left", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_env_ready"}, env_ready, 0);
    check({tag, "_log_in_valid"}, log_in_valid, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_data"}, pix_data, 0);
    check({tag, "_last_sample"}, pix_last_sample, 0);
    check({tag, "_last_line"}, pix_last_line, 0);
`ifdef LOG_COMP_STATS_EN
    check({tag, "_sat_count"}, sat_count, 0);
    check({tag, "_floor_count"}, floor_count, 0);
`endif
  endtask

  typedef struct {
    logic [22:0] floor_v;
    logic [4:0]  shift;
    logic [22:0] v;
    int          exp_pix;
    bit          exp_sat;
    bit          exp_below;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{23'h100000, 5'd11, 23'h140000, 128, 0, 0};
    tbl[1] = '{23'h100000, 5'd11, 23'h0E0000,   0, 0, 1};
    tbl[2] = '{23'h000000, 5'd0,  23'h7FFFFF, 255, 1, 0};
    tbl[3] = '{23'h000000, 5'd15, 23'h7FFFFF, 255, 0, 0};
    tbl[4] = '{23'h000000, 5'd14, 23'h7FFFFF, 255, 1, 0};
    tbl[5] = '{23'h100000, 5'd3,  23'h100000,   0, 0, 0};
    tbl[6] = '{23'h100000, 5'd3,  23'h0FFFFF,   0, 0, 1};
    tbl[7] = '{23'h000100, 5'd0,  23'h0001FF, 255, 0, 0};
    tbl[8] = '{23'h000100, 5'd0,  23'h000200, 255, 1, 0};
    tbl[9] = '{23'h000000, 5'd31, 23'h7FFFFF,   0, 0, 0};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Mapping table: each record runs a whole frame of one constant sample
    for (int i = 0; i < 10; i++) begin
      env_const_en = 1; env_const = {1'b0, tbl[i].v};
      env_mode = 2; lr_mode = 0; pr_mode = 0;
      do_start(tbl[i].floor_v, tbl[i].shift);
      wait_frame();
      check("tbl_first_pix", first_pix, tbl[i].exp_pix);
`ifdef LOG_COMP_STATS_EN
      check("tbl_sat_count", sat_count, tbl[i].exp_sat ? TOTAL : 0);
      check("tbl_floor_count", floor_count, tbl[i].exp_below ? TOTAL : 0);
`endif
    end
    env_const_en = 0;

    // Backpressure: credits stop issue at MAX_OUT
    env_mode = 2; lr_mode = 0; pr_mode = 1;
    do_start(23'h040000, 5'd10);
    repeat (20) @(negedge clk);
    check("bp_issues", n_iss, MAX_OUT);
    check("bp_env_ready", env_ready, 0);
    check("bp_pix_valid", pix_valid, 1);
    pr_mode = 0;
    wait_frame();

    // log_in_ready toggling every cycle over a whole frame
    env_mode = 2; lr_mode = 1; pr_mode = 0;
    do_start(23'h080000, 5'd12);
    wait_frame();

    // Reset mid-RUN, then a clean frame
    env_mode = 1; lr_mode = 2; pr_mode = 2;
    do_start(23'h020000, 5'd9);
    wait_issues(30);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    exp_q.delete(); exp_done = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_pix_valid", pix_valid, 0);
    check("post_reset_busy", busy, 0);
    check("post_reset_no_done", n_done, 0);
    do_start(23'h010000, 5'd8);
    wait_frame();

    // start while busy is ignored, latched floor/shift persist
    env_mode = 1; lr_mode = 2; pr_mode = 2;
    do_start(23'h180000, 5'd7);
    wait_issues(10);
    poke_start();
    wait_issues(40);
    poke_start();
    wait_frame();

    // Random frames
    for (int r = 0; r < 4; r++) begin
      env_mode = $urandom_range(1, 2); lr_mode = $urandom_range(0, 2); pr_mode = $urandom_range(0, 2);
      do_start(23'($urandom_range(0, 23'h200000)), 5'($urandom_range(6, 16)));
      wait_frame();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
